turn_signal_seq: RTL and testbench

Parametrised tail-light sequencer that generalises the fixed three-lamp left/right turn-signal FSM. It supports N lamps per side, a programmable step duration, and a hazard mode with priority and abort rules. Lamp outputs are Moore-decoded from registered state. The block sits between the driver-control inputs and the lamp drivers.

---
 rtl/turn_signal_seq_if.sv | 42 ++++
 rtl/turn_signal_seq.sv | 176 +++++++++++++++++
 tb/tb_turn_signal_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/turn_signal_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : turn_signal_seq_if
//  Description : Bundle of the driver-control requests and the lamp-drive
//                outputs of the turn-signal sequencer. The requester side
//                (master) drives the requests and observes the lamps. The
//                sequencer side (slave) consumes the requests and drives
//                the lamps.
//  Revision    : 1.0 - initial release
// ============================================================================
interface turn_signal_seq_if #(
    parameter int N_LAMPS = 3
);
    // Driver-control requests. All are level-sensitive.
    logic               left;
    logic               right;
    logic               hazard;

    // Lamp drive. Index 0 is the innermost lamp.
    logic [N_LAMPS-1:0] l_lamps;
    logic [N_LAMPS-1:0] r_lamps;
    logic               busy;

    modport master (
        output left,
        output right,
        output hazard,
        input  l_lamps,
        input  r_lamps,
        input  busy
    );

    modport slave (
        input  left,
        input  right,
        input  hazard,
        output l_lamps,
        output r_lamps,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/turn_signal_seq.sv
`default_nettype none
// ============================================================================
//  Module      : turn_signal_seq
//  Description : Parametrised tail-light sequencer. It runs an N-lamp
//                left/right sweep with a programmable step duration and a
//                hazard flash. Hazard has priority at acceptance and can
//                abort a sweep at a step boundary. Lamp outputs are
//                Moore-decoded from the registered mode and step.
//  Revision    : 1.0 - initial release
// ============================================================================
module turn_signal_seq #(
    parameter int N_LAMPS  = 3,     // lamps per side, >= 1
    parameter int TICK_DIV = 1      // clock cycles per animation step, >= 1
) (
    input  logic              clk,
    input  logic              reset,
    turn_signal_seq_if.slave  bus
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int c_STEP_W  = $clog2(N_LAMPS + 1);
    localparam int c_PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_ONE = c_PRESC_W'(1);
    localparam logic [c_STEP_W-1:0]  c_STEP_LAST = c_STEP_W'(N_LAMPS);
    localparam logic [c_STEP_W-1:0]  c_STEP_ONE  = c_STEP_W'(1);

    // ------------------------------------------------------------------
    // Mode encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LEFT   = 2'd1,
        S_RIGHT  = 2'd2,
        S_HAZ_ON = 2'd3
    } mode_t;

    // ------------------------------------------------------------------
    // State and next-state signals
    // ------------------------------------------------------------------
    mode_t                 r_mode;
    mode_t                 w_mode_nxt;
    logic [c_STEP_W-1:0]   r_step;
    logic [c_STEP_W-1:0]   w_step_nxt;
    logic [c_PRESC_W-1:0]  r_presc;
    logic [c_PRESC_W-1:0]  w_presc_nxt;

    // The prescaler reaching its top value marks a step boundary in the
    // active modes. In IDLE it marks "dark gap has elapsed".
    logic                  w_boundary;

    // Thermometer mask of the lamps that are lit for the current step.
    logic [N_LAMPS-1:0]    w_step_mask;

    // Decoded lamp drive.
    logic [N_LAMPS-1:0]    w_l_lamps;
    logic [N_LAMPS-1:0]    w_r_lamps;

    assign w_boundary = (r_presc == c_PRESC_MAX);

    // State register. Reset parks the prescaler at its top value so that a
    // request can be taken on the very first edge after reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode  <= S_IDLE;
            r_step  <= '0;
            r_presc <= c_PRESC_MAX;
        end else begin
            r_mode  <= w_mode_nxt;
            r_step  <= w_step_nxt;
            r_presc <= w_presc_nxt;
        end
    end

    // Next-state logic: request acceptance, step advance, abort and return to idle.
    always_comb begin
        w_mode_nxt  = r_mode;
        w_step_nxt  = r_step;
        w_presc_nxt = r_presc;

        case (r_mode)
            S_IDLE: begin
                if (w_boundary) begin
                    // Dark gap complete. Take the highest-priority request.
                    // With no request, the prescaler stays saturated.
                    if (bus.hazard || (bus.left && bus.right)) begin
                        w_mode_nxt  = S_HAZ_ON;
                        w_step_nxt  = '0;
                        w_presc_nxt = '0;
                    end else if (bus.left) begin
                        w_mode_nxt  = S_LEFT;
                        w_step_nxt  = c_STEP_ONE;
                        w_presc_nxt = '0;
                    end else if (bus.right) begin
                        w_mode_nxt  = S_RIGHT;
                        w_step_nxt  = c_STEP_ONE;
                        w_presc_nxt = '0;
                    end
                end else begin
                    w_presc_nxt = r_presc + c_PRESC_ONE;
                end
            end

            S_LEFT, S_RIGHT: begin
                if (w_boundary) begin
                    w_presc_nxt = '0;
                    // A hazard held at the boundary preempts the sweep.
                    // Requests seen between boundaries do nothing.
                    if (bus.hazard) begin
                        w_mode_nxt = S_HAZ_ON;
                        w_step_nxt = '0;
                    end else if (r_step < c_STEP_LAST) begin
                        w_step_nxt = r_step + c_STEP_ONE;
                    end else begin
                        w_mode_nxt = S_IDLE;
                        w_step_nxt = '0;
                    end
                end else begin
                    w_presc_nxt = r_presc + c_PRESC_ONE;
                end
            end

            S_HAZ_ON: begin
                // One on-phase only. The off-phase is the IDLE dark gap.
                // A held hazard is therefore re-accepted after TICK_DIV cycles.
                if (w_boundary) begin
                    w_mode_nxt  = S_IDLE;
                    w_step_nxt  = '0;
                    w_presc_nxt = '0;
                end else begin
                    w_presc_nxt = r_presc + c_PRESC_ONE;
                end
            end

            default: begin
                w_mode_nxt  = S_IDLE;
                w_step_nxt  = '0;
                w_presc_nxt = c_PRESC_MAX;
            end
        endcase
    end

    // Lamp i is lit while the step count exceeds its index.
    // This gives lamps[step-1:0] on and the upper lamps off.
    for (genvar gi = 0; gi < N_LAMPS; gi++) begin : g_step_mask
        localparam logic [c_STEP_W-1:0] c_IDX = c_STEP_W'(gi);
        assign w_step_mask[gi] = (r_step > c_IDX);
    end

    // Moore output decode from the registered mode and step only.
    always_comb begin
        w_l_lamps = '0;
        w_r_lamps = '0;
        case (r_mode)
            S_LEFT:   w_l_lamps = w_step_mask;
            S_RIGHT:  w_r_lamps = w_step_mask;
            S_HAZ_ON: begin
                w_l_lamps = '1;
                w_r_lamps = '1;
            end
            default: begin
                w_l_lamps = '0;
                w_r_lamps = '0;
            end
        endcase
    end

    assign bus.l_lamps = w_l_lamps;
    assign bus.r_lamps = w_r_lamps;
    assign bus.busy    = (r_mode != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_turn_signal_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_turn_signal_seq
//  Description : Directed bench for turn_signal_seq. Three instances share
//                one stimulus: A (N=3, TICK_DIV=1), B (N=4, TICK_DIV=2) and
//                C (N=3, TICK_DIV=2). Each vector names the instance whose
//                outputs it checks, one cycle after the inputs are applied.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_turn_signal_seq;

    localparam int c_SEL_A = 0;
    localparam int c_SEL_B = 1;
    localparam int c_SEL_C = 2;

    logic clk;
    logic reset;
    logic left;
    logic right;
    logic hazard;

    int n_pass;
    int n_total;

    turn_signal_seq_if #(.N_LAMPS(3)) if_a ();
    turn_signal_seq_if #(.N_LAMPS(4)) if_b ();
    turn_signal_seq_if #(.N_LAMPS(3)) if_c ();

    assign if_a.left   = left;
    assign if_a.right  = right;
    assign if_a.hazard = hazard;
    assign if_b.left   = left;
    assign if_b.right  = right;
    assign if_b.hazard = hazard;
    assign if_c.left   = left;
    assign if_c.right  = right;
    assign if_c.hazard = hazard;

    turn_signal_seq #(.N_LAMPS(3), .TICK_DIV(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    turn_signal_seq #(.N_LAMPS(4), .TICK_DIV(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    turn_signal_seq #(.N_LAMPS(3), .TICK_DIV(2)) dut_c (
        .clk   (clk),
        .reset (reset),
        .bus   (if_c)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        string      name;
        logic       rs;
        logic       l;
        logic       r;
        logic       h;
        logic [3:0] el;
        logic [3:0] er;
        logic       eb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int sel, input string name,
                       input logic rs, input logic l, input logic r, input logic h,
                       input logic [3:0] el, input logic [3:0] er, input logic eb);
        vec_t v;
        v.sel  = sel;
        v.name = name;
        v.rs   = rs;
        v.l    = l;
        v.r    = r;
        v.h    = h;
        v.el   = el;
        v.er   = er;
        v.eb   = eb;
        vecs.push_back(v);
    endtask

    // Drive inputs, let one rising edge pass, then settle before sampling.
    task automatic cyc(input logic rs, input logic l, input logic r, input logic h);
        reset  = rs;
        left   = l;
        right  = r;
        hazard = h;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input int sel, input string name,
                         input logic [3:0] el, input logic [3:0] er, input logic eb);
        logic [3:0] al;
        logic [3:0] ar;
        logic       ab;
        case (sel)
            c_SEL_A: begin
                al = {1'b0, if_a.l_lamps};
                ar = {1'b0, if_a.r_lamps};
                ab = if_a.busy;
            end
            c_SEL_B: begin
                al = if_b.l_lamps;
                ar = if_b.r_lamps;
                ab = if_b.busy;
            end
            default: begin
                al = {1'b0, if_c.l_lamps};
                ar = {1'b0, if_c.r_lamps};
                ab = if_c.busy;
            end
        endcase
        n_total++;
        if ({al, ar, ab} === {el, er, eb}) begin
            n_pass++;
        end else begin
            $display("FAIL %s (check %0d): got l=%b r=%b busy=%b, expected l=%b r=%b busy=%b",
                     name, n_total, al, ar, ab, el, er, eb);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        left    = 1'b0;
        right   = 1'b0;
        hazard  = 1'b0;

        // ---------------- vector table ----------------
        // Base config: left held, with a request already present during reset.
        add(c_SEL_A, "a_left_rst",  1, 1, 0, 0, 4'b0000, 4'b0000, 0);
        add(c_SEL_A, "a_left_s1",   0, 1, 0, 0, 4'b0001, 4'b0000, 1);
        add(c_SEL_A, "a_left_s2",   0, 1, 0, 0, 4'b0011, 4'b0000, 1);
        add(c_SEL_A, "a_left_s3",   0, 1, 0, 0, 4'b0111, 4'b0000, 1);
        add(c_SEL_A, "a_left_gap",  0, 1, 0, 0, 4'b0000, 4'b0000, 0);
        add(c_SEL_A, "a_left_rs1",  0, 1, 0, 0, 4'b0001, 4'b0000, 1);
        add(c_SEL_A, "a_left_rs2",  0, 1, 0, 0, 4'b0011, 4'b0000, 1);
        add(c_SEL_A, "a_left_rs3",  0, 1, 0, 0, 4'b0111, 4'b0000, 1);
        add(c_SEL_A, "a_left_gap2", 0, 1, 0, 0, 4'b0000, 4'b0000, 0);
        // Base config: right side.
        add(c_SEL_A, "a_right_rst", 1, 0, 0, 0, 4'b0000, 4'b0000, 0);
        add(c_SEL_A, "a_right_s1",  0, 0, 1, 0, 4'b0000, 4'b0001, 1);
        add(c_SEL_A, "a_right_s2",  0, 0, 1, 0, 4'b0000, 4'b0011, 1);
        add(c_SEL_A, "a_right_s3",  0, 0, 1, 0, 4'b0000, 4'b0111, 1);
        // Slow steps: N=4, TICK_DIV=2, right held.
        add(c_SEL_B, "b_rst",       1, 0, 1, 0, 4'b0000, 4'b0000, 0);
        add(c_SEL_B, "b_s1a",       0, 0, 1, 0, 4'b0000, 4'b0001, 1);
        add(c_SEL_B, "b_s1b",       0, 0, 1, 0, 4'b0000, 4'b0001, 1);
        add(c_SEL_B, "b_s2a",       0, 0, 1, 0, 4'b0000, 4'b0011, 1);
        add(c_SEL_B, "b_s2b",       0, 0, 1, 0, 4'b0000, 4'b0011, 1);
        add(c_SEL_B, "b_s3a",       0, 0, 1, 0, 4'b0000, 4'b0111, 1);
        add(c_SEL_B, "b_s3b",       0, 0, 1, 0, 4'b0000, 4'b0111, 1);
        add(c_SEL_B, "b_s4a",       0, 0, 1, 0, 4'b0000, 4'b1111, 1);
        add(c_SEL_B, "b_s4b",       0, 0, 1, 0, 4'b0000, 4'b1111, 1);
        add(c_SEL_B, "b_gapa",      0, 0, 1, 0, 4'b0000, 4'b0000, 0);
        add(c_SEL_B, "b_gapb",      0, 0, 1, 0, 4'b0000, 4'b0000, 0);
        add(c_SEL_B, "b_again",     0, 0, 1, 0, 4'b0000, 4'b0001, 1);
        // Simultaneous left+right behaves as hazard, then hazard alone.
        add(c_SEL_A, "a_lr_rst",    1, 0, 0, 0, 4'b0000, 4'b0000, 0);
        add(c_SEL_A, "a_lr_on1",    0, 1, 1, 0, 4'b0111, 4'b0111, 1);
        add(c_SEL_A, "a_lr_off1",   0, 1, 1, 0, 4'b0000, 4'b0000, 0);
        add(c_SEL_A, "a_lr_on2",    0, 1, 1, 0, 4'b0111, 4'b0111, 1);
        add(c_SEL_A, "a_lr_off2",   0, 1, 1, 0, 4'b0000, 4'b0000, 0);
        add(c_SEL_A, "a_haz_on1",   0, 0, 0, 1, 4'b0111, 4'b0111, 1);
        add(c_SEL_A, "a_haz_off1",  0, 0, 0, 1, 4'b0000, 4'b0000, 0);
        add(c_SEL_A, "a_haz_on2",   0, 0, 0, 1, 4'b0111, 4'b0111, 1);
        add(c_SEL_A, "a_haz_off2",  0, 0, 0, 1, 4'b0000, 4'b0000, 0);
        // Hazard outranks a single-side request at acceptance.
        add(c_SEL_A, "a_hazl_on",   0, 1, 0, 1, 4'b0111, 4'b0111, 1);
        // Early release: the sweep still completes, then stays dark.
        add(c_SEL_A, "a_rel_rst",   1, 0, 0, 0, 4'b0000, 4'b0000, 0);
        add(c_SEL_A, "a_rel_s1",    0, 1, 0, 0, 4'b0001, 4'b0000, 1);
        add(c_SEL_A, "a_rel_s2",    0, 0, 0, 0, 4'b0011, 4'b0000, 1);
        add(c_SEL_A, "a_rel_s3",    0, 0, 0, 0, 4'b0111, 4'b0000, 1);
        add(c_SEL_A, "a_rel_idle1", 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
        add(c_SEL_A, "a_rel_idle2", 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
        // Reset mid-sequence, then immediate restart.
        add(c_SEL_A, "a_mrs_rst",   1, 0, 0, 0, 4'b0000, 4'b0000, 0);
        add(c_SEL_A, "a_mrs_s1",    0, 1, 0, 0, 4'b0001, 4'b0000, 1);
        add(c_SEL_A, "a_mrs_s2",    0, 1, 0, 0, 4'b0011, 4'b0000, 1);
        add(c_SEL_A, "a_mrs_reset", 1, 1, 0, 0, 4'b0000, 4'b0000, 0);
        add(c_SEL_A, "a_mrs_re1",   0, 1, 0, 0, 4'b0001, 4'b0000, 1);
        add(c_SEL_A, "a_mrs_re2",   0, 1, 0, 0, 4'b0011, 4'b0000, 1);

        // ---------------- reset state of every instance ----------------
        cyc(1, 0, 0, 0);
        check(c_SEL_A, "rst_a", 4'b0000, 4'b0000, 0);
        check(c_SEL_B, "rst_b", 4'b0000, 4'b0000, 0);
        check(c_SEL_C, "rst_c", 4'b0000, 4'b0000, 0);

        // ---------------- table replay ----------------
        foreach (vecs[i]) begin
            cyc(vecs[i].rs, vecs[i].l, vecs[i].r, vecs[i].h);
            check(vecs[i].sel, vecs[i].name, vecs[i].el, vecs[i].er, vecs[i].eb);
        end

        // ---------------- hazard abort, N=3, TICK_DIV=2 ----------------
        // First pass: a hazard pulse between boundaries has no effect.
        cyc(1, 0, 0, 0); check(c_SEL_C, "c_rst",        4'b0000, 4'b0000, 0);
        cyc(0, 1, 0, 0); check(c_SEL_C, "c_s1a",        4'b0001, 4'b0000, 1);
        cyc(0, 0, 0, 0); check(c_SEL_C, "c_s1b",        4'b0001, 4'b0000, 1);
        cyc(0, 0, 0, 0); check(c_SEL_C, "c_s2a",        4'b0011, 4'b0000, 1);
        cyc(0, 0, 0, 1); check(c_SEL_C, "c_pulse_s2b",  4'b0011, 4'b0000, 1);
        cyc(0, 0, 0, 0); check(c_SEL_C, "c_s3a",        4'b0111, 4'b0000, 1);
        cyc(0, 0, 0, 0); check(c_SEL_C, "c_s3b",        4'b0111, 4'b0000, 1);
        cyc(0, 0, 0, 0); check(c_SEL_C, "c_gapa",       4'b0000, 4'b0000, 0);
        // Request during the first gap cycle is not accepted yet.
        cyc(0, 1, 0, 0); check(c_SEL_C, "c_gapb",       4'b0000, 4'b0000, 0);
        cyc(0, 1, 0, 0); check(c_SEL_C, "c_re_s1a",     4'b0001, 4'b0000, 1);
        cyc(0, 0, 0, 0); check(c_SEL_C, "c_re_s1b",     4'b0001, 4'b0000, 1);
        cyc(0, 0, 0, 0); check(c_SEL_C, "c_re_s2a",     4'b0011, 4'b0000, 1);
        // Second pass: hazard held through the step-2 boundary aborts.
        cyc(0, 0, 0, 1); check(c_SEL_C, "c_re_s2b",     4'b0011, 4'b0000, 1);
        cyc(0, 0, 0, 1); check(c_SEL_C, "c_abort_on1",  4'b0111, 4'b0111, 1);
        cyc(0, 0, 0, 0); check(c_SEL_C, "c_abort_on2",  4'b0111, 4'b0111, 1);
        cyc(0, 0, 0, 0); check(c_SEL_C, "c_abort_off1", 4'b0000, 4'b0000, 0);
        cyc(0, 0, 0, 0); check(c_SEL_C, "c_abort_off2", 4'b0000, 4'b0000, 0);
        cyc(0, 0, 0, 0); check(c_SEL_C, "c_idle_hold",  4'b0000, 4'b0000, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
